axis_slave_if: RTL and testbench
================================

# axis_slave_if

Upstream AXI-Stream slave stage of the FFT core. Accepts a frame of complex samples as pairs of S_TDATA_WDT beats (real beat, then imaginary beat), narrows each beat to C_SAMPLE_WDT and writes one complex sample per push into the FFT input memory. It checks frame length against TLAST and signals frame completion to the core control.

## Interface
Parameters (shared package constants):
- S_TDATA_WDT, 32, stream beat width, ≥ C_SAMPLE_WDT
- C_SAMPLE_WDT, 16, signed sample component width
- C_FFT_SIZE_LOG2, 10, input memory address width
- FFT_MEM_SIZE, 1024, complex samples per frame
- INPUT_MEM_OFFSET, 0, first write address

Ports:
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- S_AXIS_TDATA  in  S_TDATA_WDT  beat data, signed
- S_AXIS_TLAST  in  1  last beat of frame
- S_AXIS_TVALID  in  1  beat valid
- S_AXIS_TREADY  out  1  beat accepted when high with TVALID
- s_axis_if_addr  out  C_FFT_SIZE_LOG2  input memory write address
- data_re_0_in  out  C_SAMPLE_WDT  real part to memory
- data_im_0_in  out  C_SAMPLE_WDT  imaginary part to memory
- push  out  1  memory write strobe, one sample
- rx_ready  in  1  core can accept a new frame
- rx_done  out  1  one-cycle pulse, full valid frame in memory
- rx_err  out  1  sticky frame-length error
- s_axis_if_busy  out  1  FSM not idle

## Operation
- FSM states: S_IDLE, S_RECV, S_FLUSH, S_DONE.
- S_IDLE: TREADY=0. rx_ready=1 → S_RECV; clear beat/sample counters, rx_err, addr ← INPUT_MEM_OFFSET.
- S_RECV: TREADY=1 (combinational from state). Beat phase toggles on each accepted beat; phase 0 = real, latched internally; phase 1 = imaginary, triggers push.
- Last sample (count FFT_MEM_SIZE-1), imag beat accepted: TLAST=1 → S_DONE; TLAST=0 → S_FLUSH, rx_err ← 1.
- Early TLAST on any other accepted beat: rx_err ← 1, → S_IDLE. If that beat is an imaginary beat, its sample is still pushed; a lone real beat is discarded.
- S_FLUSH: TREADY=1; beats are discarded with no push; accepted TLAST → S_IDLE.
- S_DONE: one cycle, rx_done=1, → S_IDLE.
- rx_ready is ignored outside S_IDLE.
- Narrowing: the beat is interpreted as signed S_TDATA_WDT; result is the low C_SAMPLE_WDT bits (see Configuration).
- Address increments by 1 after each push and wraps modulo 2^C_FFT_SIZE_LOG2.
- s_axis_if_busy = state ≠ S_IDLE.

## Timing
- Reset values: TREADY 0, push 0, rx_done 0, rx_err 0, busy 0, addr INPUT_MEM_OFFSET, data outputs 0, state S_IDLE.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous); the partial frame is abandoned.
- push, addr and data outputs are registered. Imaginary beat accepted at edge n → push high during cycle n+1 with that sample's address and data.
- Last sample accepted at edge n → S_DONE and rx_done during cycle n+1, coincident with the final push. The core starts reading no earlier than cycle n+2.
- Throughput: one beat per cycle, one push per two cycles; TVALID gaps only stall progress.
- rx_ready edge at edge m → TREADY high from cycle m+1.

## Configuration
- S_AXIS_SAT_EN defined: saturate. If the discarded upper bits are not all equal to bit C_SAMPLE_WDT-1, clamp to +2^(C_SAMPLE_WDT-1)-1 or -2^(C_SAMPLE_WDT-1) according to the beat's sign bit.
- Undefined: plain truncation to the low C_SAMPLE_WDT bits.

## Structure
- Package axi_stream_pckg holds S_TDATA_WDT, C_SAMPLE_WDT, C_FFT_SIZE_LOG2, FFT_MEM_SIZE, INPUT_MEM_OFFSET and the FSM state typedef s_rx_state.
- One sub-module, axis_sample_narrow: combinational S_TDATA_WDT→C_SAMPLE_WDT conversion honouring S_AXIS_SAT_EN, instantiated once per component.

## Test plan
- Nominal frame: re=k, im=-k for k=0..1023, TVALID constant, TLAST on beat 2047 → 1024 pushes at addr 0..1023 with matching data; exactly one rx_done; rx_err=0.
- Random TVALID (50% gaps): same stimulus → identical memory contents; TREADY stays 1 throughout S_RECV.
- Early TLAST on beat 4 (real beat of sample 2) → 2 pushes only; rx_err=1; no rx_done; FSM in S_IDLE; TREADY=0.
- Missing TLAST plus 4 extra beats, TLAST on the 4th → 1024 pushes; extra beats accepted with no push; rx_err=1; no rx_done.
- Narrowing: re=0x0001_0000, im=0xFFFF_7FFF → with S_AXIS_SAT_EN: 0x7FFF / 0x8000; without: 0x0000 / 0x7FFF.
- rst_n low mid-frame at sample 100 → outputs reset immediately; next rx_ready starts a frame at addr 0 and completes normally.

Source files
------------

// File: rtl/axis_slave_if_pkg.sv
// Shared constants and FSM state encoding for the FFT input AXI-Stream stage.
package axi_stream_pckg;

  localparam int S_TDATA_WDT      = 32;
  localparam int C_SAMPLE_WDT     = 16;
  localparam int C_FFT_SIZE_LOG2  = 10;
  localparam int FFT_MEM_SIZE     = 1024;
  localparam int INPUT_MEM_OFFSET = 0;

  // Sample counter is one bit wider than the address so a full frame count never aliases.
  localparam int CNT_W = C_FFT_SIZE_LOG2 + 1;
  localparam logic [CNT_W-1:0]           LAST_SAMPLE = CNT_W'(FFT_MEM_SIZE - 1);
  localparam logic [C_FFT_SIZE_LOG2-1:0] ADDR_OFFSET = C_FFT_SIZE_LOG2'(INPUT_MEM_OFFSET);

  typedef logic [1:0] s_rx_state;

  localparam s_rx_state S_IDLE  = 2'd0;
  localparam s_rx_state S_RECV  = 2'd1;
  localparam s_rx_state S_FLUSH = 2'd2;
  localparam s_rx_state S_DONE  = 2'd3;

endpackage

// File: rtl/axis_slave_if_narrow.sv
// Narrows one stream beat to a signed sample component.
// S_AXIS_SAT_EN defined: out-of-range beats clamp to the sample's extreme values.
// S_AXIS_SAT_EN undefined: plain truncation to the low C_SAMPLE_WDT bits.
module axis_sample_narrow
  import axi_stream_pckg::*;
(
  input  logic [S_TDATA_WDT-1:0]  beat_i,
  output logic [C_SAMPLE_WDT-1:0] sample_o
);

  // Discarded bits plus the target sign bit; all equal means the value fits.
  logic [S_TDATA_WDT-C_SAMPLE_WDT:0] upper;
  assign upper = beat_i[S_TDATA_WDT-1:C_SAMPLE_WDT-1];

`ifdef S_AXIS_SAT_EN
  logic in_range;
  assign in_range = (&upper) | (~|upper);

  // Clamp toward the sign of the full-width beat when the value does not fit.
  always_comb begin
    sample_o = beat_i[C_SAMPLE_WDT-1:0];
    if (!in_range) begin
      if (beat_i[S_TDATA_WDT-1]) sample_o = {1'b1, {(C_SAMPLE_WDT-1){1'b0}}};
      else                       sample_o = {1'b0, {(C_SAMPLE_WDT-1){1'b1}}};
    end
  end
`else
  logic unused_upper;
  assign unused_upper = ^upper;

  // Truncation keeps only the low bits.
  always_comb begin
    sample_o = beat_i[C_SAMPLE_WDT-1:0];
  end
`endif

endmodule

// File: rtl/axis_slave_if.sv
// AXI-Stream slave feeding the FFT input memory: real/imag beat pairs become one
// registered complex-sample push; frame length is checked against TLAST.
// Optional feature macro: S_AXIS_SAT_EN (saturating narrowing, see axis_sample_narrow).
//
// Handshake: a beat transfers on a rising edge where S_AXIS_TVALID and S_AXIS_TREADY
// are both high. TREADY is a pure decode of the registered state (high in S_RECV and
// S_FLUSH) and never depends on TVALID; gaps in TVALID simply stall progress.
module axis_slave_if
  import axi_stream_pckg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [S_TDATA_WDT-1:0]     S_AXIS_TDATA,
  input  logic                       S_AXIS_TLAST,
  input  logic                       S_AXIS_TVALID,
  output logic                       S_AXIS_TREADY,
  output logic [C_FFT_SIZE_LOG2-1:0] s_axis_if_addr,
  output logic [C_SAMPLE_WDT-1:0]    data_re_0_in,
  output logic [C_SAMPLE_WDT-1:0]    data_im_0_in,
  output logic                       push,
  input  logic                       rx_ready,
  output logic                       rx_done,
  output logic                       rx_err,
  output logic                       s_axis_if_busy
);

  s_rx_state                  state_q,   state_d;
  logic                       phase_q,   phase_d;   // 0: expecting real, 1: expecting imag
  logic [C_SAMPLE_WDT-1:0]    re_lat_q,  re_lat_d;
  logic [CNT_W-1:0]           cnt_q,     cnt_d;
  logic [C_FFT_SIZE_LOG2-1:0] addr_q,    addr_d;
  logic [C_SAMPLE_WDT-1:0]    data_re_q, data_re_d;
  logic [C_SAMPLE_WDT-1:0]    data_im_q, data_im_d;
  logic                       push_q,    push_d;
  logic                       err_q,     err_d;

  logic [C_SAMPLE_WDT-1:0] re_nar;
  logic [C_SAMPLE_WDT-1:0] im_nar;
  logic                    beat_acc;

  axis_sample_narrow u_narrow_re (.beat_i(S_AXIS_TDATA), .sample_o(re_nar));
  axis_sample_narrow u_narrow_im (.beat_i(S_AXIS_TDATA), .sample_o(im_nar));

  assign S_AXIS_TREADY  = (state_q == S_RECV) || (state_q == S_FLUSH);
  assign beat_acc       = S_AXIS_TVALID && S_AXIS_TREADY;
  assign rx_done        = (state_q == S_DONE);
  assign s_axis_if_busy = (state_q != S_IDLE);
  assign s_axis_if_addr = addr_q;
  assign data_re_0_in   = data_re_q;
  assign data_im_0_in   = data_im_q;
  assign push           = push_q;
  assign rx_err         = err_q;

  // Next-state logic: frame sequencing, beat pairing and length checking.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    re_lat_d  = re_lat_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_re_d = data_re_q;
    data_im_d = data_im_q;
    push_d    = 1'b0;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (rx_ready) begin
          state_d = S_RECV;
          phase_d = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b0;
          addr_d  = ADDR_OFFSET;
        end
      end
      S_RECV: begin
        if (beat_acc) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            re_lat_d = re_nar;
            // A real beat carrying TLAST leaves a half sample: drop it.
            if (S_AXIS_TLAST) begin
              err_d   = 1'b1;
              phase_d = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            push_d    = 1'b1;
            data_re_d = re_lat_q;
            data_im_d = im_nar;
            addr_d    = ADDR_OFFSET + cnt_q[C_FFT_SIZE_LOG2-1:0];
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_SAMPLE) begin
              if (S_AXIS_TLAST) begin
                state_d = S_DONE;
              end else begin
                state_d = S_FLUSH;
                err_d   = 1'b1;
              end
            end else if (S_AXIS_TLAST) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      S_FLUSH: begin
        // Overlong frame: swallow beats until the sender closes the frame.
        if (beat_acc && S_AXIS_TLAST) state_d = S_IDLE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      re_lat_q  <= '0;
      cnt_q     <= '0;
      addr_q    <= ADDR_OFFSET;
      data_re_q <= '0;
      data_im_q <= '0;
      push_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      re_lat_q  <= re_lat_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_re_q <= data_re_d;
      data_im_q <= data_im_d;
      push_q    <= push_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_axis_slave_if.sv
// Self-checking bench for axis_slave_if. Honours S_AXIS_SAT_EN if defined for the build.
module tb_axis_slave_if;
  import axi_stream_pckg::*;

  localparam int EW = C_FFT_SIZE_LOG2 + 2 * C_SAMPLE_WDT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [S_TDATA_WDT-1:0]     S_AXIS_TDATA = '0;
  logic                       S_AXIS_TLAST = 1'b0;
  logic                       S_AXIS_TVALID = 1'b0;
  logic                       S_AXIS_TREADY;
  logic [C_FFT_SIZE_LOG2-1:0] s_axis_if_addr;
  logic [C_SAMPLE_WDT-1:0]    data_re_0_in;
  logic [C_SAMPLE_WDT-1:0]    data_im_0_in;
  logic                       push;
  logic                       rx_ready = 1'b0;
  logic                       rx_done;
  logic                       rx_err;
  logic                       s_axis_if_busy;

  axis_slave_if dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .S_AXIS_TDATA   (S_AXIS_TDATA),
    .S_AXIS_TLAST   (S_AXIS_TLAST),
    .S_AXIS_TVALID  (S_AXIS_TVALID),
    .S_AXIS_TREADY  (S_AXIS_TREADY),
    .s_axis_if_addr (s_axis_if_addr),
    .data_re_0_in   (data_re_0_in),
    .data_im_0_in   (data_im_0_in),
    .push           (push),
    .rx_ready       (rx_ready),
    .rx_done        (rx_done),
    .rx_err         (rx_err),
    .s_axis_if_busy (s_axis_if_busy)
  );

  int errors = 0;
  int checks = 0;
  int push_cnt = 0;
  int done_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [C_FFT_SIZE_LOG2-1:0] exp_addr;

  // Reference narrowing: range test on the signed value, independent of bit patterns.
  function automatic logic [C_SAMPLE_WDT-1:0] model_narrow(input logic [S_TDATA_WDT-1:0] b);
    logic [C_SAMPLE_WDT-1:0] r;
`ifdef S_AXIS_SAT_EN
    longint v, max_v, min_v;
    logic [63:0] tmp;
    v     = longint'($signed(b));
    max_v = (longint'(1) <<< (C_SAMPLE_WDT - 1)) - 1;
    min_v = -(longint'(1) <<< (C_SAMPLE_WDT - 1));
    if (v > max_v)      tmp = 64'(max_v);
    else if (v < min_v) tmp = 64'(min_v);
    else                tmp = 64'(v);
    r = tmp[C_SAMPLE_WDT-1:0];
`else
    r = b[C_SAMPLE_WDT-1:0];
`endif
    return r;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (push) begin
        push_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_push: got addr=%0d re=%h im=%h, required no push",
                   s_axis_if_addr, data_re_0_in, data_im_0_in);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          if ({s_axis_if_addr, data_re_0_in, data_im_0_in} !== e) begin
            errors++;
            $display("FAIL push_data: got addr=%0d re=%h im=%h, required addr=%0d re=%h im=%h",
                     s_axis_if_addr, data_re_0_in, data_im_0_in,
                     e[EW-1:2*C_SAMPLE_WDT], e[2*C_SAMPLE_WDT-1:C_SAMPLE_WDT], e[C_SAMPLE_WDT-1:0]);
          end
        end
      end
      if (rx_done) begin
        done_cnt++;
        checks++;
        if (push !== 1'b1) begin
          errors++;
          $display("FAIL done_with_push: push=%b during rx_done, required 1", push);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [S_TDATA_WDT-1:0] d, input logic last);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    S_AXIS_TDATA  = d;
    S_AXIS_TLAST  = last;
    S_AXIS_TVALID = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (S_AXIS_TREADY === 1'b1) ok = 1;
      n++;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL tready_timeout: TREADY=%b after 50 cycles, required 1", S_AXIS_TREADY);
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic gap_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      checks++;
      if (S_AXIS_TREADY !== 1'b1) begin
        errors++;
        $display("FAIL tready_in_gap: got %b, required 1", S_AXIS_TREADY);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_sample(input logic [S_TDATA_WDT-1:0] re, input logic [S_TDATA_WDT-1:0] im,
                             input logic last_on_im, input logic expect_push, input bit gaps);
    if (gaps) gap_cycles($urandom_range(0, 1));
    send_beat(re, 1'b0);
    if (gaps) gap_cycles($urandom_range(0, 1));
    if (expect_push) begin
      exp_q.push_back({exp_addr, model_narrow(re), model_narrow(im)});
      exp_addr++;
    end
    send_beat(im, last_on_im);
    checks++;
    if (push !== expect_push) begin
      errors++;
      $display("FAIL push_latency: push=%b one cycle after imag beat, required %b", push, expect_push);
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    exp_addr = C_FFT_SIZE_LOG2'(INPUT_MEM_OFFSET);
    push_cnt = 0;
    done_cnt = 0;
    checks++;
    if (S_AXIS_TREADY !== 1'b1) begin
      errors++;
      $display("FAIL rx_ready_latency: TREADY=%b cycle after rx_ready, required 1", S_AXIS_TREADY);
    end
  endtask

  task automatic wait_idle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_end(input string name, input int exp_push, input int exp_done, input logic exp_err);
    checks++;
    if (push_cnt !== exp_push) begin
      errors++;
      $display("FAIL %s_push_count: got %0d, required %0d", name, push_cnt, exp_push);
    end
    checks++;
    if (done_cnt !== exp_done) begin
      errors++;
      $display("FAIL %s_done_count: got %0d, required %0d", name, done_cnt, exp_done);
    end
    checks++;
    if (rx_err !== exp_err) begin
      errors++;
      $display("FAIL %s_rx_err: got %b, required %b", name, rx_err, exp_err);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_push: got %0d outstanding, required 0", name, exp_q.size());
    end
    checks++;
    if (s_axis_if_busy !== 1'b0 || S_AXIS_TREADY !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got busy=%b tready=%b, required 0/0", name, s_axis_if_busy, S_AXIS_TREADY);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({S_AXIS_TREADY, push, rx_done, rx_err, s_axis_if_busy} !== 5'b0) begin
      errors++;
      $display("FAIL %s_flags: got tready=%b push=%b done=%b err=%b busy=%b, required all 0",
               name, S_AXIS_TREADY, push, rx_done, rx_err, s_axis_if_busy);
    end
    checks++;
    if (s_axis_if_addr !== C_FFT_SIZE_LOG2'(INPUT_MEM_OFFSET) || data_re_0_in !== '0 || data_im_0_in !== '0) begin
      errors++;
      $display("FAIL %s_data: got addr=%0d re=%h im=%h, required addr=%0d re=0 im=0",
               name, s_axis_if_addr, data_re_0_in, data_im_0_in, INPUT_MEM_OFFSET);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_released");
  endtask

  task automatic test_nominal(input bit gaps);
    start_frame();
    for (int k = 0; k < FFT_MEM_SIZE; k++)
      send_sample(S_TDATA_WDT'(k), S_TDATA_WDT'(-k), (k == FFT_MEM_SIZE - 1), 1'b1, gaps);
    checks++;
    if (rx_done !== 1'b1) begin
      errors++;
      $display("FAIL rx_done_timing: got %b cycle after last beat, required 1", rx_done);
    end
    wait_idle();
    check_end(gaps ? "gapped" : "nominal", FFT_MEM_SIZE, 1, 1'b0);
  endtask

  task automatic test_early_tlast();
    start_frame();
    send_sample(32'd0, 32'd0, 1'b0, 1'b1, 0);
    send_sample(32'd1, -32'd1, 1'b0, 1'b1, 0);
    send_beat(32'd2, 1'b1);
    wait_idle();
    check_end("early_tlast", 2, 0, 1'b1);
  endtask

  task automatic test_missing_tlast();
    start_frame();
    for (int k = 0; k < FFT_MEM_SIZE; k++)
      send_sample(S_TDATA_WDT'(3 * k), S_TDATA_WDT'(-7 * k), 1'b0, 1'b1, 0);
    checks++;
    if (rx_err !== 1'b1 || s_axis_if_busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_entry: got err=%b busy=%b, required 1/1", rx_err, s_axis_if_busy);
    end
    for (int j = 0; j < 4; j++) send_beat(S_TDATA_WDT'($urandom), (j == 3));
    wait_idle();
    check_end("missing_tlast", FFT_MEM_SIZE, 0, 1'b1);
  endtask

  task automatic test_narrow();
    logic [C_SAMPLE_WDT-1:0] exp_re, exp_im;
`ifdef S_AXIS_SAT_EN
    exp_re = 16'h7FFF;
    exp_im = 16'h8000;
`else
    exp_re = 16'h0000;
    exp_im = 16'h7FFF;
`endif
    start_frame();
    send_sample(32'h0001_0000, 32'hFFFF_7FFF, 1'b0, 1'b1, 0);
    checks++;
    if (data_re_0_in !== exp_re || data_im_0_in !== exp_im) begin
      errors++;
      $display("FAIL narrow_const: got re=%h im=%h, required re=%h im=%h",
               data_re_0_in, data_im_0_in, exp_re, exp_im);
    end
    send_sample(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 0);
    send_sample(32'hFFFF_8000, 32'h0000_7FFF, 1'b1, 1'b1, 0);
    wait_idle();
    check_end("narrow", 3, 0, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    start_frame();
    for (int k = 0; k < 100; k++)
      send_sample(S_TDATA_WDT'(k + 5), S_TDATA_WDT'(k * 11), 1'b0, 1'b1, 0);
    send_beat(32'd100, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_nominal(0);
  endtask

  initial begin
    test_reset();
    test_nominal(0);
    test_nominal(1);
    test_early_tlast();
    test_missing_tlast();
    test_narrow();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
